// File: rtl/sensor_pkg.sv
// sensor_pkg: shared definitions for the A/B vehicle-presence sensor protocol.
// Holds the passage state encoding, direction codes and the {A,B} pattern
// tables. The pattern generator, the entry/exit detector and their benches
// all import this package so that the protocol is defined in one place.
package sensor_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PH1  = 3'd1,
      PH2  = 3'd2,
      PH3  = 3'd3,
      GAP  = 3'd4
   } state_t;

   localparam logic DIR_ENTRY = 1'b0;
   localparam logic DIR_EXIT  = 1'b1;

   // {A,B} per state, indexed by state_t value (IDLE, PH1, PH2, PH3, GAP).
   localparam logic [1:0] PAT_ENTRY [5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
   localparam logic [1:0] PAT_EXIT  [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};

   function automatic logic [1:0] pattern_of(input logic dir, input state_t st);
      logic [1:0] pat;
      case (st)
         PH1, PH2, PH3, GAP:
            pat = (dir == DIR_EXIT) ? PAT_EXIT[st] : PAT_ENTRY[st];
         default:
            pat = 2'b00;
      endcase
      return pat;
   endfunction

   function automatic state_t next_phase(input state_t st);
      state_t nxt;
      case (st)
         PH1:     nxt = PH2;
         PH2:     nxt = PH3;
         PH3:     nxt = GAP;
         default: nxt = IDLE;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/tick_phase_counter.sv
// tick_phase_counter: counts tick-enable pulses within one sensor phase.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_en         : count this cycle (tick while a passage is running)
//   i_clr        : force the count back to zero (abort)
//   o_tc         : terminal count, high when the counted tick is the last
//                  one of the phase; the count wraps to zero on it
module tick_phase_counter
   import sensor_pkg::*;
#(
   parameter int PHASE_TICKS = 50,
   parameter int CNT_W       = 8
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tc
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_last;

   assign w_last = (r_cnt == CNT_W'(PHASE_TICKS - 1));
   assign o_tc   = i_en & w_last;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr || o_tc) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sensor_pattern_gen.sv
// sensor_pattern_gen: transmit end of the A/B sensor protocol. One accepted
// start request plays one complete entry or exit passage on the A/B lines:
// three sensor phases followed by a release gap, each PHASE_TICKS ticks long.
// Ports:
//   CLK, RST : system clock, asynchronous active-high reset
//   tick     : one-CLK enable strobe; phase timing counts only these
//   start    : request a passage (accepted only when idle)
//   dir      : 0 = entry, 1 = exit; latched when start is accepted
//   abort    : cancel the running passage, lines released next cycle
//   A, B     : registered sensor lines, 1 = blocked
//   busy     : passage in progress
//   done     : one-cycle pulse when a passage completes normally
module sensor_pattern_gen
   import sensor_pkg::*;
#(
   parameter int PHASE_TICKS = 50,
   parameter int CNT_W       = 8
) (
   input  logic CLK,
   input  logic RST,
   input  logic tick,
   input  logic start,
   input  logic dir,
   input  logic abort,
   output logic A,
   output logic B,
   output logic busy,
   output logic done
);

   state_t     r_state;
   logic       r_dir;
   logic [1:0] r_ab;
   logic       r_busy;
   logic       r_done;

   logic w_active;
   logic w_abort;
   logic w_cnt_en;
   logic w_tc;

   assign w_active = (r_state != IDLE);
   // abort only matters while a passage runs, and it outranks tick
   assign w_abort  = abort & w_active;
   assign w_cnt_en = tick & w_active & ~abort;

   tick_phase_counter #(
      .PHASE_TICKS (PHASE_TICKS),
      .CNT_W       (CNT_W)
   ) u_cnt (
      .i_clk (CLK),
      .i_rst (RST),
      .i_en  (w_cnt_en),
      .i_clr (w_abort),
      .o_tc  (w_tc)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= IDLE;
         r_dir   <= DIR_ENTRY;
         r_ab    <= 2'b00;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_abort) begin
            r_state <= IDLE;
            r_ab    <= 2'b00;
            r_busy  <= 1'b0;
         end else if (r_state == IDLE) begin
            // a tick coinciding with start is deliberately not counted
            if (start) begin
               r_dir   <= dir;
               r_state <= PH1;
               r_busy  <= 1'b1;
               r_ab    <= pattern_of(dir, PH1);
            end
         end else if (w_tc) begin
            r_state <= next_phase(r_state);
            r_ab    <= pattern_of(r_dir, next_phase(r_state));
            if (r_state == GAP) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign A    = r_ab[1];
   assign B    = r_ab[0];
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_sensor_pattern_gen.sv
// Bench for sensor_pattern_gen. Two instances share all inputs: one with
// PHASE_TICKS=2 and one with PHASE_TICKS=1. A tick-count model predicts
// every output of both on every cycle; directed scenarios add literal checks.
module tb_sensor_pattern_gen;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic tick = 1'b0;
   logic start = 1'b0;
   logic dir = 1'b0;
   logic abort = 1'b0;

   logic A2, B2, busy2, done2;
   logic A1, B1, busy1, done1;

   int errs = 0;
   int checks = 0;
   int tick_mode = 0;   // 0: every 4 CLK, 1: random, 2: held low, 3: held high
   int tick_div = 0;

   always #5 CLK = ~CLK;

   sensor_pattern_gen #(.PHASE_TICKS(2), .CNT_W(8)) dut (
      .CLK(CLK), .RST(RST), .tick(tick), .start(start), .dir(dir), .abort(abort),
      .A(A2), .B(B2), .busy(busy2), .done(done2));

   sensor_pattern_gen #(.PHASE_TICKS(1), .CNT_W(8)) dut1 (
      .CLK(CLK), .RST(RST), .tick(tick), .start(start), .dir(dir), .abort(abort),
      .A(A1), .B(B1), .busy(busy1), .done(done1));

   always @(negedge CLK) begin
      tick_div = (tick_div + 1) % 4;
      case (tick_mode)
         0:       tick = (tick_div == 0);
         1:       tick = ($urandom_range(0, 2) == 0);
         2:       tick = 1'b0;
         default: tick = 1'b1;
      endcase
   end

   // ---------------- behavioural model ----------------
   // A passage is described only by how many ticks have elapsed since it was
   // accepted: the phase is ticks/PT, and it ends after 4*PT ticks.
   logic m_busy [2] = '{1'b0, 1'b0};
   logic m_dir  [2] = '{1'b0, 1'b0};
   logic m_done [2] = '{1'b0, 1'b0};
   int   m_ticks[2] = '{0, 0};

   function automatic int pt_of(input int k);
      return (k == 0) ? 2 : 1;
   endfunction

   function automatic logic [1:0] exp_ab(input logic b, input logic d, input int t, input int pt);
      int ph;
      if (!b) return 2'b00;
      ph = t / pt;
      if (!d) begin
         case (ph)
            0: return 2'b10;
            1: return 2'b11;
            2: return 2'b01;
            default: return 2'b00;
         endcase
      end else begin
         case (ph)
            0: return 2'b01;
            1: return 2'b11;
            2: return 2'b10;
            default: return 2'b00;
         endcase
      end
   endfunction

   always @(posedge CLK or posedge RST) begin
      for (int k = 0; k < 2; k++) begin
         logic nb, nd, ndn;
         int nt;
         nb = m_busy[k]; nd = m_dir[k]; nt = m_ticks[k]; ndn = 1'b0;
         if (RST) begin
            nb = 1'b0; nd = 1'b0; nt = 0;
         end else if (m_busy[k]) begin
            if (abort) begin
               nb = 1'b0; nt = 0;
            end else if (tick) begin
               nt = nt + 1;
               if (nt == 4 * pt_of(k)) begin
                  nb = 1'b0; ndn = 1'b1; nt = 0;
               end
            end
         end else if (start) begin
            nb = 1'b1; nd = dir; nt = 0;
         end
         m_busy[k]  <= nb;
         m_dir[k]   <= nd;
         m_ticks[k] <= nt;
         m_done[k]  <= ndn;
      end
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge CLK) begin
      #1;
      chk("model_ab_pt2", {6'd0, A2, B2}, {6'd0, exp_ab(m_busy[0], m_dir[0], m_ticks[0], 2)});
      chk("model_busy_pt2", {7'd0, busy2}, {7'd0, m_busy[0]});
      chk("model_done_pt2", {7'd0, done2}, {7'd0, m_done[0]});
      chk("model_ab_pt1", {6'd0, A1, B1}, {6'd0, exp_ab(m_busy[1], m_dir[1], m_ticks[1], 1)});
      chk("model_busy_pt1", {7'd0, busy1}, {7'd0, m_busy[1]});
      chk("model_done_pt1", {7'd0, done1}, {7'd0, m_done[1]});
   end

   // ---------------- directed helpers ----------------
   logic [1:0] seq_q[$];
   int         chg_cyc[$];
   int         ndone;

   task automatic start_pass(input logic d);
      @(negedge CLK); start = 1'b1; dir = d;
      @(negedge CLK); start = 1'b0; dir = 1'b0;
   endtask

   task automatic watch(input int ncyc);
      logic [1:0] last;
      seq_q.delete(); chg_cyc.delete(); ndone = 0;
      last = {A2, B2};
      seq_q.push_back(last); chg_cyc.push_back(0);
      for (int i = 1; i <= ncyc; i++) begin
         @(negedge CLK);
         if (done2) ndone++;
         if ({A2, B2} != last) begin
            last = {A2, B2};
            seq_q.push_back(last); chg_cyc.push_back(i);
         end
      end
   endtask

   task automatic wait_ab(input logic [1:0] v, input int maxc, input string nm);
      int n;
      n = 0;
      while ({A2, B2} != v && n < maxc) begin
         @(negedge CLK); n++;
      end
      chk(nm, {6'd0, A2, B2}, {6'd0, v});
   endtask

   task automatic check_seq(input string nm, input logic [1:0] e0, input logic [1:0] e1,
                            input logic [1:0] e2, input logic [1:0] e3, input int n);
      logic [1:0] e[4];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      chk({nm, "_len"}, 8'(seq_q.size()), 8'(n));
      for (int i = 0; i < n && i < seq_q.size(); i++)
         chk({nm, "_step"}, {6'd0, seq_q[i]}, {6'd0, e[i]});
   endtask

   task automatic abort_pulse();
      @(negedge CLK); abort = 1'b1;
      @(negedge CLK); abort = 1'b0;
   endtask

   initial begin
      int n;
      repeat (3) @(negedge CLK);
      chk("reset_ab", {6'd0, A2, B2}, 8'd0);
      chk("reset_busy", {7'd0, busy2}, 8'd0);
      chk("reset_done", {7'd0, done2}, 8'd0);
      RST = 1'b0;
      repeat (2) @(negedge CLK);

      // entry passage
      start_pass(1'b0);
      chk("entry_busy_lat", {7'd0, busy2}, 8'd1);
      watch(45);
      check_seq("entry_seq", 2'b10, 2'b11, 2'b01, 2'b00, 4);
      chk("entry_ph2_len", 8'(chg_cyc[2] - chg_cyc[1]), 8'd8);
      chk("entry_ph3_len", 8'(chg_cyc[3] - chg_cyc[2]), 8'd8);
      chk("entry_ph1_len_ok", {7'd0, (chg_cyc[1] >= 5 && chg_cyc[1] <= 8)}, 8'd1);
      chk("entry_done_cnt", 8'(ndone), 8'd1);
      chk("entry_idle_after", {7'd0, busy2}, 8'd0);

      // a second entry, then an exit
      start_pass(1'b0); watch(45);
      chk("entry2_done_cnt", 8'(ndone), 8'd1);
      start_pass(1'b1);
      watch(45);
      check_seq("exit_seq", 2'b01, 2'b11, 2'b10, 2'b00, 4);
      chk("exit_done_cnt", 8'(ndone), 8'd1);

      // start with dir=1 during PH2 is ignored
      start_pass(1'b0);
      wait_ab(2'b11, 40, "ign_reach_ph2");
      @(negedge CLK); start = 1'b1; dir = 1'b1;
      @(negedge CLK); start = 1'b0; dir = 1'b0;
      watch(40);
      check_seq("ign_seq", 2'b11, 2'b01, 2'b00, 2'b00, 3);
      chk("ign_done_cnt", 8'(ndone), 8'd1);
      chk("ign_no_second", {7'd0, busy2}, 8'd0);

      // abort in PH2, then immediate restart
      repeat (20) @(negedge CLK);
      start_pass(1'b0);
      wait_ab(2'b11, 40, "abort_reach_ph2");
      @(negedge CLK); abort = 1'b1;
      @(negedge CLK); abort = 1'b0;
      chk("abort_ab", {6'd0, A2, B2}, 8'd0);
      chk("abort_busy", {7'd0, busy2}, 8'd0);
      chk("abort_done", {7'd0, done2}, 8'd0);
      start = 1'b1; dir = 1'b0;
      @(negedge CLK); start = 1'b0;
      chk("abort_restart_busy", {7'd0, busy2}, 8'd1);
      chk("abort_restart_ab", {6'd0, A2, B2}, 8'h02);
      abort_pulse();
      repeat (20) @(negedge CLK);

      // asynchronous reset in PH3
      start_pass(1'b0);
      wait_ab(2'b01, 40, "rst_reach_ph3");
      #2 RST = 1'b1;
      #1;
      chk("rst_async_ab", {6'd0, A2, B2}, 8'd0);
      chk("rst_async_busy", {7'd0, busy2}, 8'd0);
      @(negedge CLK); RST = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_after_busy", {7'd0, busy2}, 8'd0);
      chk("rst_after_done", {7'd0, done2}, 8'd0);

      // no ticks: PH1 holds
      tick_mode = 2;
      repeat (2) @(negedge CLK);
      start_pass(1'b0);
      repeat (100) @(negedge CLK);
      chk("notick_ab", {6'd0, A2, B2}, 8'h02);
      chk("notick_busy", {7'd0, busy2}, 8'd1);
      chk("notick_ab_pt1", {6'd0, A1, B1}, 8'h02);
      abort_pulse();

      // tick held high with PHASE_TICKS=1: one phase per CLK
      tick_mode = 3;
      repeat (2) @(negedge CLK);
      start_pass(1'b0);
      n = 0;
      while (!done1 && n < 20) begin
         @(negedge CLK); n++;
      end
      chk("pt1_done_latency", 8'(n), 8'd4);
      abort_pulse();
      repeat (4) @(negedge CLK);

      // randomized traffic
      tick_mode = 1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         start = ($urandom_range(0, 7) == 0);
         dir   = 1'($urandom_range(0, 1));
         abort = ($urandom_range(0, 39) == 0);
      end
      @(negedge CLK); start = 1'b0; abort = 1'b0; dir = 1'b0;
      repeat (5) @(negedge CLK);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
      $fatal(1, "watchdog expired");
   end

endmodule
